dac_serial_capture: RTL and testbench

- Receive-side model of the DAC serial link: deserializes the SYNC/SCLK/DIN stream produced by the DAC output channel back into parallel words, all in the dataclk domain.
- Used in simulation benches and as an on-chip loopback monitor, letting DAC_register contents be checked against what actually went out on the wire.
- Checks frame framing and reports malformed frames.

---
 rtl/dac_link_pkg.sv | 20 ++
 rtl/dac_edge_detect.sv | 23 ++
 rtl/dac_serial_capture.sv | 132 +++++++++++++
 tb/tb_dac_serial_capture.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dac_link_pkg.sv
// dac_link_pkg: shared DAC serial link definitions.
// FSM state encoding, frame geometry and frame field offsets.
package dac_link_pkg;

  localparam int DAC_FRAME_BITS = 24;
  localparam int DAC_DATA_BITS  = 16;
  localparam int DAC_PD_BITS    = 2;

  localparam int DAC_DATA_LSB = 0;
  localparam int DAC_DATA_MSB = DAC_DATA_LSB + DAC_DATA_BITS - 1;
  localparam int DAC_PD_LSB   = DAC_DATA_MSB + 1;
  localparam int DAC_PD_MSB   = DAC_PD_LSB + DAC_PD_BITS - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } dac_state_e;

endpackage

// File: rtl/dac_edge_detect.sv
// dac_edge_detect: registers one input, emits rise/fall pulses.
// Ports: dataclk, reset (sync, active low), d in; rise, fall out.
module dac_edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic dataclk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge dataclk) begin
    if (!reset) d_q <= RST_VAL;
    else        d_q <= d;
  end

  assign rise = ~d_q & d;
  assign fall = d_q & ~d;

endmodule

// File: rtl/dac_serial_capture.sv
// dac_serial_capture: deserializes DAC SYNC/SCLK/DIN frames to words.
// Ports: dataclk, reset, DAC_SYNC/SCLK/DIN, capture_en in;
// dac_word, pd_mode, word_valid, frame_error, busy, frame_count,
// error_count out. Macro DAC_CAPTURE_SIGNED_EN adds dac_signed.
module dac_serial_capture
  import dac_link_pkg::*;
#(
  parameter int FRAME_BITS = DAC_FRAME_BITS,
  parameter int DATA_BITS  = DAC_DATA_BITS,
  parameter int PD_BITS    = DAC_PD_BITS,
  parameter int CNT_W      = 16
) (
  input  logic                 dataclk,
  input  logic                 reset,
  input  logic                 DAC_SYNC,
  input  logic                 DAC_SCLK,
  input  logic                 DAC_DIN,
  input  logic                 capture_en,
  output logic [DATA_BITS-1:0] dac_word,
  output logic [PD_BITS-1:0]   pd_mode,
  output logic                 word_valid,
  output logic                 frame_error,
  output logic                 busy,
`ifdef DAC_CAPTURE_SIGNED_EN
  output logic [DATA_BITS-1:0] dac_signed,
`endif
  output logic [CNT_W-1:0]     frame_count,
  output logic [CNT_W-1:0]     error_count
);

  // Only the trailing PD+DATA bits matter; older bits fall off the top.
  localparam int SR_W = DATA_BITS + PD_BITS;
  localparam int BC_W = $clog2(FRAME_BITS + 1);

  localparam logic [BC_W-1:0]  BC_END  = BC_W'(FRAME_BITS);
  localparam logic [BC_W-1:0]  BC_ONE  = BC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  dac_state_e       state;
  logic [SR_W-1:0]  sr;
  logic [BC_W-1:0]  bit_cnt;
  logic             fall_sync;
  logic             rise_sync;
  logic             fall_sclk;

  dac_edge_detect #(.RST_VAL(1'b1)) u_sync (
    .dataclk (dataclk),
    .reset   (reset),
    .d       (DAC_SYNC),
    .rise    (rise_sync),
    .fall    (fall_sync)
  );

  dac_edge_detect #(.RST_VAL(1'b1)) u_sclk (
    .dataclk (dataclk),
    .reset   (reset),
    .d       (DAC_SCLK),
    .rise    (),
    .fall    (fall_sclk)
  );

  always_ff @(posedge dataclk) begin
    if (!reset) begin
      state       <= IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      dac_word    <= '0;
      pd_mode     <= '0;
      word_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
      error_count <= '0;
`ifdef DAC_CAPTURE_SIGNED_EN
      dac_signed  <= {1'b1, {(DATA_BITS-1){1'b0}}};
`endif
    end else begin
      word_valid  <= 1'b0;
      frame_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall_sync && capture_en) begin
            state   <= SHIFT;
            sr      <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_cnt == BC_END) begin
            dac_word    <= sr[DATA_BITS-1:0];
            pd_mode     <= sr[SR_W-1:DATA_BITS];
            word_valid  <= 1'b1;
            frame_count <= frame_count + CNT_ONE;
`ifdef DAC_CAPTURE_SIGNED_EN
            dac_signed  <= {~sr[DATA_BITS-1], sr[DATA_BITS-2:0]};
`endif
            // A SYNC rise coinciding with completion must not be lost.
            if (rise_sync) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= HOLD;
            end
          end else if (rise_sync) begin
            // SYNC wins over a simultaneous SCLK fall.
            frame_error <= 1'b1;
            if (error_count != CNT_MAX)
              error_count <= error_count + CNT_ONE;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (fall_sclk) begin
            sr      <= {sr[SR_W-2:0], DAC_DIN};
            bit_cnt <= bit_cnt + BC_ONE;
          end
        end
        HOLD: begin
          if (rise_sync) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_serial_capture.sv
// tb_dac_serial_capture: scoreboard bench for dac_serial_capture.
// Directed frames; monitor pops expected results on each pulse.
module tb_dac_serial_capture;

  logic        dataclk;
  logic        reset;
  logic        DAC_SYNC;
  logic        DAC_SCLK;
  logic        DAC_DIN;
  logic        capture_en;
  logic [15:0] dac_word;
  logic [1:0]  pd_mode;
  logic        word_valid;
  logic        frame_error;
  logic        busy;
  logic [15:0] frame_count;
  logic [15:0] error_count;
`ifdef DAC_CAPTURE_SIGNED_EN
  logic [15:0] dac_signed;
`endif

  dac_serial_capture dut (
    .dataclk     (dataclk),
    .reset       (reset),
    .DAC_SYNC    (DAC_SYNC),
    .DAC_SCLK    (DAC_SCLK),
    .DAC_DIN     (DAC_DIN),
    .capture_en  (capture_en),
    .dac_word    (dac_word),
    .pd_mode     (pd_mode),
    .word_valid  (word_valid),
    .frame_error (frame_error),
    .busy        (busy),
`ifdef DAC_CAPTURE_SIGNED_EN
    .dac_signed  (dac_signed),
`endif
    .frame_count (frame_count),
    .error_count (error_count)
  );

  initial dataclk = 1'b0;
  always #5 dataclk = ~dataclk;

  typedef struct {
    logic        err;
    logic [15:0] word;
    logic [1:0]  pd;
    logic [15:0] fc;
    logic [15:0] ec;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge dataclk);
  endtask

  task automatic push(input logic err, input logic [15:0] w,
                      input logic [1:0] pd, input logic [15:0] fc,
                      input logic [15:0] ec);
    exp_t e;
    e.err = err; e.word = w; e.pd = pd; e.fc = fc; e.ec = ec;
    exp_q.push_back(e);
  endtask

  // Drive nfalls SCLK falls; bits past 24 are ones.
  task automatic bits(input logic [23:0] frame, input int nfalls);
    for (int i = 0; i < nfalls; i++) begin
      DAC_SCLK = 1'b1;
      DAC_DIN  = (i < 24) ? frame[23-i] : 1'b1;
      cyc(2);
      DAC_SCLK = 1'b0;
      cyc(2);
    end
    DAC_SCLK = 1'b1;
    cyc(2);
  endtask

  task automatic frame_tx(input logic [23:0] frame, input int nfalls);
    DAC_SYNC = 1'b0;
    cyc(2);
    bits(frame, nfalls);
    DAC_SYNC = 1'b1;
    cyc(5);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_word"},  dac_word,    0);
    chk({tag, "_pd"},    pd_mode,     0);
    chk({tag, "_valid"}, word_valid,  0);
    chk({tag, "_err"},   frame_error, 0);
    chk({tag, "_busy"},  busy,        0);
    chk({tag, "_fc"},    frame_count, 0);
    chk({tag, "_ec"},    error_count, 0);
`ifdef DAC_CAPTURE_SIGNED_EN
    chk({tag, "_signed"}, dac_signed, 32'h8000);
`endif
  endtask

  always @(negedge dataclk) begin
    if (reset && (word_valid || frame_error)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: valid=%b err=%b word=%h",
                 word_valid, frame_error, dac_word);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_valid", word_valid, !e.err);
        chk("mon_error", frame_error, e.err);
        chk("mon_word", dac_word, e.word);
        chk("mon_pd", pd_mode, e.pd);
        chk("mon_fc", frame_count, e.fc);
        chk("mon_ec", error_count, e.ec);
`ifdef DAC_CAPTURE_SIGNED_EN
        chk("mon_signed", dac_signed, e.word ^ 16'h8000);
`endif
      end
    end
  end

  initial begin
    reset      = 1'b0;
    DAC_SYNC   = 1'b1;
    DAC_SCLK   = 1'b1;
    DAC_DIN    = 1'b0;
    capture_en = 1'b1;
    cyc(3);
    chk_zero("rst");
    reset = 1'b1;
    cyc(3);

    push(1'b0, 16'hBEEF, 2'b00, 16'd1, 16'd0);
    DAC_SYNC = 1'b0;
    cyc(3);
    chk("busy_shift", busy, 1);
    bits(24'h00BEEF, 24);
    DAC_SYNC = 1'b1;
    cyc(5);
    chk("busy_idle", busy, 0);

    push(1'b0, 16'h1234, 2'b10, 16'd2, 16'd0);
    frame_tx(24'h021234, 24);

    push(1'b1, 16'h1234, 2'b10, 16'd2, 16'd1);
    frame_tx(24'hFFFFFF, 10);

    push(1'b0, 16'h00FF, 2'b00, 16'd3, 16'd1);
    frame_tx(24'h0000FF, 30);

    DAC_SYNC = 1'b0;
    cyc(2);
    bits(24'hFFFFFF, 12);
    DAC_SYNC = 1'b1;
    reset    = 1'b0;
    cyc(3);
    chk_zero("midrst");
    reset = 1'b1;
    cyc(3);

    push(1'b0, 16'h8000, 2'b00, 16'd1, 16'd0);
    frame_tx(24'h008000, 24);

    capture_en = 1'b0;
    DAC_SYNC = 1'b0;
    cyc(3);
    chk("busy_disabled", busy, 0);
    bits(24'h01ABCD, 24);
    DAC_SYNC = 1'b1;
    cyc(5);
    chk("fc_disabled", frame_count, 1);
    chk("ec_disabled", error_count, 0);

    capture_en = 1'b1;
    push(1'b0, 16'hABCD, 2'b01, 16'd2, 16'd0);
    frame_tx(24'h01ABCD, 24);

    cyc(10);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
